fib_seq_gen: RTL and testbench
==============================

# fib_seq_gen

Parametrised Fibonacci sequence generator with a start/valid/ready interface, selectable streaming or final-term-only output, and configurable overflow handling (wrap or saturate) with per-term overflow flagging. It is the next generation of the team's fixed 32-bit free-running Fibonacci counter. Downstream consumers either pull the whole series F(0)..F(n) under backpressure or receive only F(n).

## Interface
- WIDTH, 32: data width of every term (≥2)
- IDX_W, 6: width of the term index n (max n = 2^IDX_W − 1)
- SAT, 0: overflow policy; 0 = wrap modulo 2^WIDTH, 1 = saturate to all-ones
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start_i  in  1  request a new run; accepted only in IDLE
- n_i  in  IDX_W  index of last term; sampled on start acceptance
- mode_i  in  1  0 = stream F(0)..F(n), 1 = emit F(n) only; sampled on start acceptance
- busy_o  out  1  high while not in IDLE
- out_valid_o  out  1  output term valid
- out_ready_i  in  1  consumer accepts term when valid & ready
- out_data_o  out  WIDTH  term value
- out_idx_o  out  IDX_W  index k of presented term
- out_last_o  out  1  presented term is F(n)
- out_ovf_o  out  1  presented term is not the exact Fibonacci value (wrapped or saturated)
- done_o  out  1  one-cycle pulse after the last term's handshake

## Operation
- Internal registers: a = F(k), b = F(k+1), each with an overflow flag a_f, b_f; counter k; latched n, mode.
- Advance step: a ← b, a_f ← b_f; sum = a + b computed at WIDTH+1 bits; carry = sum[WIDTH]; b_f ← carry | a_f | b_f; b ← SAT ? (carry ? all-ones : sum[WIDTH−1:0]) : sum[WIDTH−1:0]; k ← k+1. Once saturated, b stays all-ones.
- States: IDLE, STREAM, CALC, HOLD.
- IDLE: start_i high → load a=0, b=1, flags=0, k=0, latch n_i/mode_i; go STREAM if mode_i=0 else CALC. start_i is ignored in all other states (no queuing).
- STREAM: out_valid_o=1, data=a, idx=k, last=(k==n), ovf=a_f. On handshake: last → IDLE; else advance step. Without handshake all outputs and state hold.
- CALC: out_valid_o=0; k==n → HOLD, else advance step (one term per cycle).
- HOLD: out_valid_o=1, data=a, idx=n, last=1, ovf=a_f; on handshake → IDLE.
- done_o pulses high for exactly one cycle on the cycle after the final handshake (coincident with the first IDLE cycle).
- n=0: single term 0 with last=1 in either mode.
- Reset (any state, mid-run included): immediately IDLE; all outputs 0; a, b, k, flags cleared. No partial-run output afterwards.

## Timing
- Reset values: busy_o=0, out_valid_o=0, out_data_o=0, out_idx_o=0, out_last_o=0, out_ovf_o=0, done_o=0.
- Stream latency: start accepted at edge E → first term valid in the cycle after E; with out_ready_i held high, one term per cycle, n+1 valid cycles, back-to-back.
- Final-only latency: valid in the cycle after edge E+n+1 (n CALC advance cycles + 1 transition).
- Outputs are registered or decoded from state/registers only; no combinational path from out_ready_i to any output.
- A new start is accepted at earliest the cycle done_o is high (IDLE).
- busy_o high from the cycle after acceptance until the cycle done_o pulses.

## Test plan
- Stream, WIDTH=32, n=10, ready=1: 11 consecutive valids, data 0,1,1,2,3,5,8,13,21,34,55, idx 0..10, last only on 55, ovf=0, done_o one cycle after.
- Stream n=5 with ready toggled 1/0 every cycle: same 6 values in order, each held stable across stall cycles, no drops/duplicates.
- Final-only, WIDTH=32, n=47: single valid n+1=48 cycles after start, data 0xB11924E1, ovf=0; n=48, SAT=0 → 0x1E8D0A40, ovf=1; SAT=1 → 0xFFFFFFFF, ovf=1.
- WIDTH=8 stream n=15, SAT=0: F(13)=233 ovf=0, F(14)=121 ovf=1, F(15)=98 ovf=1; SAT=1: F(14)=255, F(15)=255, ovf=1.
- n=0 both modes: one valid, data 0, idx 0, last=1; start_i pulses during busy ignored (no extra terms).
- rst_n asserted mid-stream at k=4 with ready low: outputs 0 asynchronously, busy_o=0, no done_o; subsequent start n=3 yields 0,1,1,2 cleanly.

Source files
------------

// File: rtl/fib_seq_gen.sv
// Fibonacci term generator: streams F(0)..F(n) under backpressure or presents
// only F(n), with wrap or saturate overflow and a per-term overflow flag.
module fib_seq_gen #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 6,
  parameter int SAT   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [IDX_W-1:0] n_i,
  input  logic             mode_i,
  output logic             busy_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [IDX_W-1:0] out_idx_o,
  output logic             out_last_o,
  output logic             out_ovf_o,
  output logic             done_o
);

  typedef enum logic [1:0] {IDLE, STREAM, CALC, HOLD} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b;
  logic             r_af, r_bf;
  logic [IDX_W-1:0] r_k, r_n;
  logic             r_done;

  logic             w_load, w_adv, w_fin, w_at_n;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_b_nxt;

  assign w_at_n  = (r_k == r_n);
  assign w_sum   = {1'b0, r_a} + {1'b0, r_b};
  // Saturation keeps b pinned at all-ones since any later sum carries again.
  assign w_b_nxt = (SAT != 0 && w_sum[WIDTH]) ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_adv  = 1'b0;
    w_fin  = 1'b0;
    case (r_state)
      IDLE: if (start_i) begin
        w_load = 1'b1;
        w_next = mode_i ? CALC : STREAM;
      end
      STREAM: if (out_ready_i) begin
        if (w_at_n) begin
          w_fin  = 1'b1;
          w_next = IDLE;
        end else begin
          w_adv = 1'b1;
        end
      end
      CALC: if (w_at_n) w_next = HOLD;
            else        w_adv  = 1'b1;
      HOLD: if (out_ready_i) begin
        w_fin  = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_af   <= 1'b0;
      r_bf   <= 1'b0;
      r_k    <= '0;
      r_n    <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_fin;
      if (w_load) begin
        r_a  <= '0;
        r_b  <= {{(WIDTH-1){1'b0}}, 1'b1};
        r_af <= 1'b0;
        r_bf <= 1'b0;
        r_k  <= '0;
        r_n  <= n_i;
      end else if (w_adv) begin
        r_a  <= r_b;
        r_af <= r_bf;
        r_b  <= w_b_nxt;
        r_bf <= w_sum[WIDTH] | r_af | r_bf;
        r_k  <= r_k + IDX_W'(1);
      end
    end
  end

  // Outputs are gated by state so IDLE/CALC present zeros regardless of stale registers.
  assign busy_o      = (r_state != IDLE);
  assign out_valid_o = (r_state == STREAM) || (r_state == HOLD);
  assign out_data_o  = out_valid_o ? r_a : '0;
  assign out_idx_o   = (r_state == STREAM) ? r_k : (r_state == HOLD) ? r_n : '0;
  assign out_last_o  = (r_state == HOLD) || ((r_state == STREAM) && w_at_n);
  assign out_ovf_o   = out_valid_o & r_af;
  assign done_o      = r_done;

endmodule

// File: tb/tb_fib_seq_gen.sv
// Directed bench for fib_seq_gen: four instances (32/8-bit, wrap/saturate) share stimulus.
module tb_fib_seq_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_i = 1'b0;
  logic [5:0] n_i = '0;
  logic       mode_i = 1'b0;
  logic       out_ready_i = 1'b0;

  logic        busy_a, vld_a, last_a, ovf_a, done_a;
  logic [31:0] data_a;
  logic [5:0]  idx_a;
  logic        busy_b, vld_b, last_b, ovf_b, done_b;
  logic [31:0] data_b;
  logic [5:0]  idx_b;
  logic        busy_c, vld_c, last_c, ovf_c, done_c;
  logic [7:0]  data_c;
  logic [5:0]  idx_c;
  logic        busy_d, vld_d, last_d, ovf_d, done_d;
  logic [7:0]  data_d;
  logic [5:0]  idx_d;

  int chk = 0;
  int err = 0;

  always #5 clk = ~clk;

  fib_seq_gen #(.WIDTH(32), .IDX_W(6), .SAT(0)) u_w32 (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .n_i(n_i), .mode_i(mode_i),
    .busy_o(busy_a), .out_valid_o(vld_a), .out_ready_i(out_ready_i), .out_data_o(data_a),
    .out_idx_o(idx_a), .out_last_o(last_a), .out_ovf_o(ovf_a), .done_o(done_a));
  fib_seq_gen #(.WIDTH(32), .IDX_W(6), .SAT(1)) u_s32 (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .n_i(n_i), .mode_i(mode_i),
    .busy_o(busy_b), .out_valid_o(vld_b), .out_ready_i(out_ready_i), .out_data_o(data_b),
    .out_idx_o(idx_b), .out_last_o(last_b), .out_ovf_o(ovf_b), .done_o(done_b));
  fib_seq_gen #(.WIDTH(8), .IDX_W(6), .SAT(0)) u_w8 (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .n_i(n_i), .mode_i(mode_i),
    .busy_o(busy_c), .out_valid_o(vld_c), .out_ready_i(out_ready_i), .out_data_o(data_c),
    .out_idx_o(idx_c), .out_last_o(last_c), .out_ovf_o(ovf_c), .done_o(done_c));
  fib_seq_gen #(.WIDTH(8), .IDX_W(6), .SAT(1)) u_s8 (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .n_i(n_i), .mode_i(mode_i),
    .busy_o(busy_d), .out_valid_o(vld_d), .out_ready_i(out_ready_i), .out_data_o(data_d),
    .out_idx_o(idx_d), .out_last_o(last_d), .out_ovf_o(ovf_d), .done_o(done_d));

  // Hand-computed F(0)..F(15)
  logic [31:0] fib [16] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 377, 610};

  // Pulses start for one edge; returns at the negedge after acceptance.
  task automatic start_run(input logic [5:0] n, input logic m);
    @(negedge clk);
    start_i = 1'b1; n_i = n; mode_i = m;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    chk++;
    if ({busy_a, vld_a, data_a, idx_a, last_a, ovf_a, done_a} !== '0) begin
      err++; $display("FAIL reset_outputs: got busy=%0b vld=%0b data=%0h idx=%0d last=%0b ovf=%0b done=%0b, need all 0",
                      busy_a, vld_a, data_a, idx_a, last_a, ovf_a, done_a);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk++;
    if ({busy_a, vld_a, done_a} !== 3'b000) begin
      err++; $display("FAIL reset_idle: busy=%0b vld=%0b done=%0b, need 0", busy_a, vld_a, done_a);
    end
  endtask

  task automatic test_stream;
    out_ready_i = 1'b1;
    start_run(6'd10, 1'b0);
    for (int i = 0; i <= 10; i++) begin
      chk++;
      if (vld_a !== 1'b1 || data_a !== fib[i] || idx_a !== 6'(i) || last_a !== (i == 10) ||
          ovf_a !== 1'b0 || busy_a !== 1'b1) begin
        err++; $display("FAIL stream_term%0d: vld=%0b data=%0d idx=%0d last=%0b ovf=%0b busy=%0b, need 1 %0d %0d %0b 0 1",
                        i, vld_a, data_a, idx_a, last_a, ovf_a, busy_a, fib[i], i, (i == 10));
      end
      @(negedge clk);
    end
    chk++;
    if (done_a !== 1'b1 || vld_a !== 1'b0 || busy_a !== 1'b0) begin
      err++; $display("FAIL stream_done: done=%0b vld=%0b busy=%0b, need 1 0 0", done_a, vld_a, busy_a);
    end
    @(negedge clk);
    chk++;
    if (done_a !== 1'b0) begin
      err++; $display("FAIL stream_done_pulse: done=%0b, need 0", done_a);
    end
  endtask

  task automatic test_stall;
    int e = 0;
    int cyc = 0;
    out_ready_i = 1'b1;
    start_run(6'd5, 1'b0);
    while (e < 6 && cyc < 40) begin
      out_ready_i = cyc[0] ? 1'b0 : 1'b1;
      chk++;
      if (vld_a !== 1'b1 || data_a !== fib[e] || idx_a !== 6'(e) || last_a !== (e == 5)) begin
        err++; $display("FAIL stall_term%0d: vld=%0b data=%0d idx=%0d last=%0b, need 1 %0d %0d %0b",
                        e, vld_a, data_a, idx_a, last_a, fib[e], e, (e == 5));
      end
      if (out_ready_i && vld_a) e++;
      cyc++;
      @(negedge clk);
    end
    chk++;
    if (e != 6 || done_a !== 1'b1 || vld_a !== 1'b0) begin
      err++; $display("FAIL stall_done: terms=%0d done=%0b vld=%0b, need 6 1 0", e, done_a, vld_a);
    end
    out_ready_i = 1'b1;
  endtask

  task automatic final_wait(input logic [5:0] n, output int cnt);
    cnt = 0;
    start_run(n, 1'b1);
    while (vld_a !== 1'b1 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic test_final;
    int cnt;
    out_ready_i = 1'b1;
    final_wait(6'd47, cnt);
    chk++;
    if (cnt != 48) begin
      err++; $display("FAIL final47_latency: %0d cycles, need 48", cnt);
    end
    chk++;
    if (data_a !== 32'hB11924E1 || ovf_a !== 1'b0 || idx_a !== 6'd47 || last_a !== 1'b1 ||
        data_b !== 32'hB11924E1 || ovf_b !== 1'b0) begin
      err++; $display("FAIL final47_value: w=%0h ovf=%0b idx=%0d last=%0b s=%0h sovf=%0b, need b11924e1 0 47 1 b11924e1 0",
                      data_a, ovf_a, idx_a, last_a, data_b, ovf_b);
    end
    @(negedge clk);
    chk++;
    if (done_a !== 1'b1 || vld_a !== 1'b0) begin
      err++; $display("FAIL final47_done: done=%0b vld=%0b, need 1 0", done_a, vld_a);
    end
    final_wait(6'd48, cnt);
    chk++;
    if (cnt != 49 || data_a !== 32'h1E8D0A40 || ovf_a !== 1'b1) begin
      err++; $display("FAIL final48_wrap: cyc=%0d data=%0h ovf=%0b, need 49 1e8d0a40 1", cnt, data_a, ovf_a);
    end
    chk++;
    if (data_b !== 32'hFFFFFFFF || ovf_b !== 1'b1) begin
      err++; $display("FAIL final48_sat: data=%0h ovf=%0b, need ffffffff 1", data_b, ovf_b);
    end
    @(negedge clk);
  endtask

  task automatic test_width8;
    logic [7:0] ew [16];
    logic [7:0] es [16];
    for (int i = 0; i < 16; i++) begin
      ew[i] = fib[i][7:0];
      es[i] = fib[i][7:0];
    end
    ew[14] = 8'd121; ew[15] = 8'd98;
    es[14] = 8'd255; es[15] = 8'd255;
    out_ready_i = 1'b1;
    start_run(6'd15, 1'b0);
    for (int i = 0; i <= 15; i++) begin
      chk++;
      if (vld_c !== 1'b1 || data_c !== ew[i] || ovf_c !== (i >= 14) || idx_c !== 6'(i)) begin
        err++; $display("FAIL w8wrap_term%0d: vld=%0b data=%0d ovf=%0b idx=%0d, need 1 %0d %0b %0d",
                        i, vld_c, data_c, ovf_c, idx_c, ew[i], (i >= 14), i);
      end
      chk++;
      if (vld_d !== 1'b1 || data_d !== es[i] || ovf_d !== (i >= 14)) begin
        err++; $display("FAIL w8sat_term%0d: vld=%0b data=%0d ovf=%0b, need 1 %0d %0b",
                        i, vld_d, data_d, ovf_d, es[i], (i >= 14));
      end
      @(negedge clk);
    end
    chk++;
    if (done_c !== 1'b1 || done_d !== 1'b1) begin
      err++; $display("FAIL w8_done: wrap=%0b sat=%0b, need 1 1", done_c, done_d);
    end
  endtask

  task automatic test_n0;
    out_ready_i = 1'b1;
    start_run(6'd0, 1'b0);
    start_i = 1'b1;
    chk++;
    if (vld_a !== 1'b1 || data_a !== 32'd0 || idx_a !== 6'd0 || last_a !== 1'b1) begin
      err++; $display("FAIL n0_stream: vld=%0b data=%0d idx=%0d last=%0b, need 1 0 0 1", vld_a, data_a, idx_a, last_a);
    end
    @(negedge clk);
    start_i = 1'b0;
    chk++;
    if (done_a !== 1'b1 || vld_a !== 1'b0 || busy_a !== 1'b0) begin
      err++; $display("FAIL n0_stream_done: done=%0b vld=%0b busy=%0b, need 1 0 0", done_a, vld_a, busy_a);
    end
    start_run(6'd0, 1'b1);
    start_i = 1'b1;
    chk++;
    if (vld_a !== 1'b0 || busy_a !== 1'b1) begin
      err++; $display("FAIL n0_calc: vld=%0b busy=%0b, need 0 1", vld_a, busy_a);
    end
    @(negedge clk);
    start_i = 1'b0;
    chk++;
    if (vld_a !== 1'b1 || data_a !== 32'd0 || idx_a !== 6'd0 || last_a !== 1'b1) begin
      err++; $display("FAIL n0_final: vld=%0b data=%0d idx=%0d last=%0b, need 1 0 0 1", vld_a, data_a, idx_a, last_a);
    end
    @(negedge clk);
    chk++;
    if (done_a !== 1'b1 || vld_a !== 1'b0) begin
      err++; $display("FAIL n0_final_done: done=%0b vld=%0b, need 1 0", done_a, vld_a);
    end
    repeat (2) begin
      @(negedge clk);
      chk++;
      if (vld_a !== 1'b0 || busy_a !== 1'b0) begin
        err++; $display("FAIL n0_no_extra: vld=%0b busy=%0b, need 0 0", vld_a, busy_a);
      end
    end
  endtask

  task automatic test_midrun_reset;
    out_ready_i = 1'b1;
    start_run(6'd10, 1'b0);
    repeat (4) @(negedge clk);
    out_ready_i = 1'b0;
    @(negedge clk);
    chk++;
    if (vld_a !== 1'b1 || idx_a !== 6'd4 || data_a !== 32'd3) begin
      err++; $display("FAIL rst_pre_k4: vld=%0b idx=%0d data=%0d, need 1 4 3", vld_a, idx_a, data_a);
    end
    #2 rst_n = 1'b0;
    #1;
    chk++;
    if ({busy_a, vld_a, data_a, idx_a, last_a, ovf_a, done_a} !== '0) begin
      err++; $display("FAIL rst_async: busy=%0b vld=%0b data=%0d idx=%0d last=%0b done=%0b, need all 0",
                      busy_a, vld_a, data_a, idx_a, last_a, done_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready_i = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk++;
      if (done_a !== 1'b0 || vld_a !== 1'b0) begin
        err++; $display("FAIL rst_no_done: done=%0b vld=%0b, need 0 0", done_a, vld_a);
      end
    end
    start_run(6'd3, 1'b0);
    for (int i = 0; i <= 3; i++) begin
      chk++;
      if (vld_a !== 1'b1 || data_a !== fib[i] || idx_a !== 6'(i) || last_a !== (i == 3)) begin
        err++; $display("FAIL rst_rerun_term%0d: vld=%0b data=%0d idx=%0d last=%0b, need 1 %0d %0d %0b",
                        i, vld_a, data_a, idx_a, last_a, fib[i], i, (i == 3));
      end
      @(negedge clk);
    end
    chk++;
    if (done_a !== 1'b1) begin
      err++; $display("FAIL rst_rerun_done: done=%0b, need 1", done_a);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_final();
    test_width8();
    test_n0();
    test_midrun_reset();
    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
